// File: rtl/err_pkg.sv
// Shared constants for the error-rate monitor feeding the dynamic-TMR control unit.
package err_pkg;

  localparam int ERR_W = 4;
  localparam logic [ERR_W-1:0] ERR_MAX = 4'd15;

  localparam logic [2:0] EN_TMR     = 3'b111;
  localparam logic [2:0] EN_SIMPLEX = 3'b001;

  localparam int DEF_WIDTH = 8;

  // Add a single mismatch to a count without wrapping past ERR_MAX.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] cnt, input logic inc);
    if (inc && (cnt != ERR_MAX)) begin
      return cnt + ERR_W'(1);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/tmr_vote.sv
// Combinational bitwise majority voter; simplex mode passes lane 0 through unflagged.
module tmr_vote #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] r0,
  input  logic [WIDTH-1:0] r1,
  input  logic [WIDTH-1:0] r2,
  input  logic             tmr_mode,
  output logic [WIDTH-1:0] voted,
  output logic [2:0]       lane_err
);

  logic [WIDTH-1:0] maj;

  assign maj = (r0 & r1) | (r0 & r2) | (r1 & r2);

  always_comb begin
    voted    = r0;
    lane_err = 3'b000;
    if (tmr_mode) begin
      voted    = maj;
      lane_err = {(r2 != maj), (r1 != maj), (r0 != maj)};
    end
  end

endmodule

// File: rtl/err_rate_mon.sv
// Votes replica outputs and publishes the mismatch count of each window of
// WIN accepted samples as a saturating 4-bit err_rate.
module err_rate_mon
  import err_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int WIN   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] r0,
  input  logic [WIDTH-1:0] r1,
  input  logic [WIDTH-1:0] r2,
  input  logic [2:0]       en,
  output logic             out_valid,
  output logic [WIDTH-1:0] voted,
  output logic [2:0]       lane_err,
  output logic [ERR_W-1:0] err_rate,
  output logic             win_done
);

  localparam int CNT_W = (WIN > 1) ? $clog2(WIN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIN - 1);

  logic [WIDTH-1:0] vote_word;
  logic [2:0]       vote_lane;
  logic             mismatch;
  logic             closing;
  logic [ERR_W-1:0] err_sum;
  logic [CNT_W-1:0] sample_cnt;
  logic [ERR_W-1:0] err_cnt;

  tmr_vote #(.WIDTH(WIDTH)) u_vote (
    .r0       (r0),
    .r1       (r1),
    .r2       (r2),
    .tmr_mode (en == EN_TMR),
    .voted    (vote_word),
    .lane_err (vote_lane)
  );

  assign mismatch = |vote_lane;
  assign closing  = (sample_cnt == LAST);
  // The closing sample's own mismatch belongs to the window it closes.
  assign err_sum  = sat_inc(err_cnt, mismatch);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      voted      <= '0;
      lane_err   <= 3'b000;
      err_rate   <= '0;
      win_done   <= 1'b0;
      sample_cnt <= '0;
      err_cnt    <= '0;
    end else if (in_valid) begin
      out_valid <= 1'b1;
      voted     <= vote_word;
      lane_err  <= vote_lane;
      if (closing) begin
        err_rate   <= err_sum;
        err_cnt    <= '0;
        sample_cnt <= '0;
        win_done   <= 1'b1;
      end else begin
        err_cnt    <= err_sum;
        sample_cnt <= sample_cnt + CNT_W'(1);
        win_done   <= 1'b0;
      end
    end else begin
      out_valid <= 1'b0;
      win_done  <= 1'b0;
    end
  end

endmodule

// File: doc/err_rate_mon.md
Name: err_rate_mon

Overview:
- Upstream stage of the dynamic-TMR control unit.
- Majority-votes three replica datapath outputs and flags which lane disagreed.
- Counts vote mismatches over fixed windows of accepted samples and publishes a saturating 4-bit err_rate.
- The control unit compares err_rate against its threshold (>5) to decide between simplex and full TMR; the control unit's en output feeds back into this block to select the vote mode.

Parameters:
- WIDTH, 8: bit width of each replica data word.
- WIN, 16: accepted samples per measurement window; legal range 2..1024.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- in_valid  in  1  replica words r0/r1/r2 are valid this cycle.
- r0  in  WIDTH  replica 0 output; the only lane used in simplex mode.
- r1  in  WIDTH  replica 1 output.
- r2  in  WIDTH  replica 2 output.
- en  in  3  lane enables from the control unit: 3'b111 = TMR, anything else = simplex on lane 0.
- out_valid  out  1  voted/lane_err are valid this cycle.
- voted  out  WIDTH  voted (TMR) or pass-through (simplex) data word.
- lane_err  out  3  bit i = lane i disagreed with the voted word.
- err_rate  out  4  mismatch count of the last completed window, saturated at 15.
- win_done  out  1  one-cycle pulse: err_rate was updated this cycle.

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, voted=0, lane_err=0, err_rate=0, win_done=0, sample counter=0, error counter=0. All values hold while rst_n stays low.
- Accept rule: a sample is accepted on any clock edge with in_valid=1. No backpressure; the block accepts every cycle.
- TMR mode (en==3'b111):
  - voted = bitwise majority(r0,r1,r2).
  - lane_err[i] = (r_i != voted).
  - mismatch = |lane_err.
- Simplex mode (any other en):
  - voted = r0.
  - lane_err = 3'b000.
  - mismatch = 0.
- en is sampled together with its data. A mode change takes effect on the very sample it accompanies, with no window restart.
- Latency: exactly 1 cycle.
  - out_valid, voted and lane_err are registered on the accepting edge.
  - out_valid=0 in any cycle following in_valid=0; voted and lane_err hold their last values.
- Window counters:
  - sample_cnt runs 0..WIN-1 and increments per accepted sample.
  - err_cnt is 4 bits, adds mismatch per accepted sample, and saturates at 15 (no wrap).
- Window close: on an accepted sample with sample_cnt==WIN-1:
  - err_rate <= min(15, err_cnt+mismatch).
  - err_cnt <= 0 and sample_cnt <= 0.
  - win_done=1 for that one cycle, coincident with out_valid for that sample.
- err_rate is held between window closes and never changes outside a win_done cycle.
- Idle cycles (in_valid=0) advance no counters.
- Reset mid-window: partial counts are discarded and err_rate returns to 0.
- An error on the closing sample counts toward the closing window, not the next one.

Decomposition:
- Shared package err_pkg holds:
  - ERR_W=4 and ERR_MAX=15.
  - EN_TMR=3'b111 and EN_SIMPLEX=3'b001.
  - The WIDTH default.
- Sub-module tmr_vote (combinational, parameter WIDTH):
  - Inputs: r0, r1, r2, tmr_mode.
  - Outputs: voted, lane_err.
- err_rate_mon holds only registers, counters and window logic.

Test Plan:
- Reset: assert rst_n=0 mid-stream after 5 mismatching samples. Expect all outputs 0 immediately (asynchronous). After release with 4 clean samples (WIN=4), expect err_rate=0 and win_done on the 4th sample.
- Majority vote: WIDTH=8, en=111, r0=8'hA5, r1=8'hA5, r2=8'h5A. Expect next cycle out_valid=1, voted=8'hA5, lane_err=3'b100.
- Bitwise vote: r0=8'hF0, r1=8'h0F, r2=8'hFF. Expect voted=8'hFF, lane_err=3'b011.
- Simplex: en=001, r0=8'h11, r1=8'h22, r2=8'h33. Expect voted=8'h11, lane_err=000, and no error counted.
- Window count: WIN=4, en=111, samples with mismatches in positions 2 and 4 (4 being the closing sample), in_valid gaps inserted between samples. Expect win_done exactly once, err_rate=2, held through the next window until its close.
- Saturation: WIN=32, 20 of 32 samples mismatching. Expect err_rate=15. A following clean window gives err_rate=0, and a mode switch en 111->001 mid-window causes no counter reset.
